// File: rtl/acc_sequencer.sv
// acc_sequencer: three-cycle fetch/decode/execute controller for a 16-bit accumulator machine
module acc_sequencer (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    output logic [10:0] ProgAddr,
    input  logic [15:0] ProgData,
    output logic [10:0] DataAddr,
    output logic        DataWr,
    output logic [15:0] ImmExt,
    output logic [1:0]  Sel,
    input  logic [15:0] MuxOut,
    output logic [15:0] AccOut,
    output logic        Busy,
    output logic        Halted
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} stateT;

    localparam logic [4:0] opHlt  = 5'd0;
    localparam logic [4:0] opSto  = 5'd1;
    localparam logic [4:0] opLd   = 5'd2;
    localparam logic [4:0] opLdi  = 5'd3;
    localparam logic [4:0] opAdd  = 5'd4;
    localparam logic [4:0] opAddi = 5'd5;
    localparam logic [4:0] opSub  = 5'd6;
    localparam logic [4:0] opSubi = 5'd7;

    localparam logic [1:0] selMem = 2'b00;
    localparam logic [1:0] selImm = 2'b01;
    localparam logic [1:0] selAcc = 2'b10;

    stateT       state;
    logic [10:0] pc;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic [1:0]  selDecode;

    assign opcode   = ir[15:11];
    assign ProgAddr = pc;
    assign DataAddr = ir[10:0];
    assign ImmExt   = {{5{ir[10]}}, ir[10:0]};

    // Operand source for the upcoming EXEC: memory, immediate, or the accumulator for STO and NOPs
    always_comb begin
        selDecode = (opcode == opLd || opcode == opAdd || opcode == opSub) ? selMem :
                    (opcode == opLdi || opcode == opAddi || opcode == opSubi) ? selImm : selAcc;
    end

    // Sequencer: state, PC, IR, accumulator and the registered control outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            pc     <= '0;
            ir     <= '0;
            AccOut <= '0;
            Sel    <= selAcc;
            DataWr <= 1'b0;
            Busy   <= 1'b0;
            Halted <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        pc     <= '0;
                        state  <= FETCH;
                        Busy   <= 1'b1;
                        Halted <= 1'b0;
                    end
                end
                FETCH: begin
                    ir    <= ProgData;
                    state <= DECODE;
                end
                DECODE: begin
                    pc <= pc + 11'd1;
                    if (opcode == opHlt) begin
                        state  <= HALT;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                    end else begin
                        state  <= EXEC;
                        Sel    <= selDecode;
                        DataWr <= (opcode == opSto);
                    end
                end
                EXEC: begin
                    case (opcode)
                        opLd, opLdi:   AccOut <= MuxOut;
                        opAdd, opAddi: AccOut <= AccOut + MuxOut;
                        opSub, opSubi: AccOut <= AccOut - MuxOut;
                        default:       AccOut <= AccOut;
                    endcase
                    Sel    <= selAcc;
                    DataWr <= 1'b0;
                    state  <= FETCH;
                end
                default: begin
                    state  <= IDLE;
                    Sel    <= selAcc;
                    DataWr <= 1'b0;
                    Busy   <= 1'b0;
                    Halted <= 1'b0;
                end
            endcase
        end
    end
endmodule
